// File: rtl/line_window_reader.sv
// Line-buffer side controller: writes the incoming raster pixel stream into the
// line storage, reads back the previous-line column and builds an n x n binary window.
//
// state | meaning
// IDLE  | waiting for the first pixel of a frame
// RUN   | accepting pixels of the current frame
// DONE  | last pixel taken, draining the pipeline until FrameDone
module line_window_reader #(
    parameter int ImageWidth  = 7,
    parameter int ImageHeight = 7,
    parameter int WindowSize  = 3,
    localparam int AddrWidth  = $clog2(ImageWidth + 1)
) (
    input  logic                               Clock,
    input  logic                               nReset,
    input  logic                               InValid,
    input  logic                               InData,
    output logic                               InReady,
    output logic                               BufWriteEnable,
    output logic [AddrWidth-1:0]               BufAddr,
    output logic                               BufData,
    input  logic [WindowSize-2:0]              BufLineData,
    output logic                               WindowValid,
    output logic [WindowSize*WindowSize-1:0]   Window,
    output logic [AddrWidth:0]                 WindowRow,
    output logic [AddrWidth-1:0]               WindowCol,
    output logic                               FrameDone
);

    localparam int N = WindowSize;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [AddrWidth-1:0] LastCol   = AddrWidth'(ImageWidth - 1);
    localparam logic [AddrWidth:0]   LastRow   = (AddrWidth + 1)'(ImageHeight - 1);
    localparam logic [AddrWidth-1:0] FirstCol  = AddrWidth'(N - 1);
    localparam logic [AddrWidth:0]   FirstRow  = (AddrWidth + 1)'(N - 1);

    logic [1:0]             state;
    logic [AddrWidth-1:0]   col;
    logic [AddrWidth:0]     row;
    logic [AddrWidth-1:0]   last_addr;
    logic                   accept;
    logic                   last_pixel;

    logic                   s1_valid;
    logic                   s1_pixel;
    logic                   s1_last;
    logic [AddrWidth-1:0]   s1_col;
    logic [AddrWidth:0]     s1_row;
    logic                   s2_last;

    logic [N-1:0]           col_vec;
    logic [N*N-1:0]         window_next;

    // A pixel presented while reset is asserted is not taken, so the storage
    // interface stays quiet during reset.
    assign InReady    = (state != StDone);
    assign accept     = InValid & InReady & nReset;
    assign last_pixel = (row == LastRow) && (col == LastCol);

    assign BufWriteEnable = accept;
    assign BufAddr        = accept ? col : last_addr;
    assign BufData        = accept & InData;

    assign col_vec = {s1_pixel, BufLineData};

    always_comb begin
        window_next = Window;
        for (int r = 0; r < N; r++) begin
            window_next[r*N +: N] = {col_vec[r], Window[r*N+1 +: N-1]};
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state <= StIdle;
        end else begin
            case (state)
                StIdle:  if (accept) state <= last_pixel ? StDone : StRun;
                StRun:   if (accept && last_pixel) state <= StDone;
                StDone:  if (FrameDone) state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            col       <= '0;
            row       <= '0;
            last_addr <= '0;
        end else if (accept) begin
            last_addr <= col;
            if (col == LastCol) begin
                col <= '0;
                row <= (row == LastRow) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            s1_valid <= 1'b0;
            s1_pixel <= 1'b0;
            s1_last  <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            s1_valid <= accept;
            s1_last  <= accept & last_pixel;
            if (accept) begin
                s1_pixel <= InData;
                s1_col   <= col;
                s1_row   <= row;
            end
        end
    end

    // The window shifts only on accepted pixels; columns left over from the
    // previous line are hidden because WindowValid is low for col < n-1.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            Window      <= '0;
            WindowValid <= 1'b0;
            WindowRow   <= '0;
            WindowCol   <= '0;
            s2_last     <= 1'b0;
            FrameDone   <= 1'b0;
        end else begin
            WindowValid <= s1_valid && (s1_row >= FirstRow) && (s1_col >= FirstCol);
            s2_last     <= s1_valid & s1_last;
            FrameDone   <= s2_last;
            if (s1_valid) begin
                Window    <= window_next;
                WindowRow <= s1_row;
                WindowCol <= s1_col;
            end
        end
    end

endmodule

// File: tb/tb_line_window_reader.sv
// Directed bench for line_window_reader: models the shift-chain line storage and
// checks windows against images built from known pixel patterns.
module tb_line_window_reader;

    localparam int W  = 7;
    localparam int H  = 7;
    localparam int N  = 3;
    localparam int AW = 3;

    logic           Clock = 1'b0;
    logic           nReset;
    logic           InValid;
    logic           InData;
    logic           InReady;
    logic           BufWriteEnable;
    logic [AW-1:0]  BufAddr;
    logic           BufData;
    logic [N-2:0]   BufLineData;
    logic           WindowValid;
    logic [N*N-1:0] Window;
    logic [AW:0]    WindowRow;
    logic [AW-1:0]  WindowCol;
    logic           FrameDone;

    line_window_reader #(.ImageWidth(W), .ImageHeight(H), .WindowSize(N)) dut (
        .Clock(Clock), .nReset(nReset), .InValid(InValid), .InData(InData),
        .InReady(InReady), .BufWriteEnable(BufWriteEnable), .BufAddr(BufAddr),
        .BufData(BufData), .BufLineData(BufLineData), .WindowValid(WindowValid),
        .Window(Window), .WindowRow(WindowRow), .WindowCol(WindowCol),
        .FrameDone(FrameDone)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // line storage: bit 0 oldest line, bit n-2 previous line; read-before-write
    logic [N-2:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        BufLineData = '0;
    end
    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (BufWriteEnable === 1'b1) begin
            BufLineData  <= mem[BufAddr];
            mem[BufAddr] <= {BufData, mem[BufAddr][N-2:1]};
        end
    end

    logic [N*N-1:0] win_q[$];
    logic [AW:0]    row_q[$];
    logic [AW-1:0]  col_q[$];
    int fd_cnt, fd_cyc, first_win_cyc;
    int we_err, addr_err, tmo_err;
    int acc22, acc_last;
    int last_col_tb;

    always @(negedge Clock) begin
        if (WindowValid === 1'b1) begin
            if (win_q.size() == 0) first_win_cyc = cyc;
            win_q.push_back(Window);
            row_q.push_back(WindowRow);
            col_q.push_back(WindowCol);
        end
        if (FrameDone === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    function automatic logic pix(input int pat, input int r, input int c);
        case (pat)
            0:       return 1'b1;
            1:       return 1'((r + c) & 1);
            default: return 1'(((r * 5 + c * 3 + r * c) % 7) > 3);
        endcase
    endfunction

    function automatic logic [N*N-1:0] exp_win(input int pat, input int rr, input int cc);
        logic [N*N-1:0] w;
        w = '0;
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++)
                w[r*N+k] = pix(pat, rr - (N-1) + r, cc - (N-1) + k);
        return w;
    endfunction

    task automatic clear_rec();
        win_q.delete(); row_q.delete(); col_q.delete();
        fd_cnt = 0; fd_cyc = -1; first_win_cyc = -1;
        we_err = 0; addr_err = 0; tmo_err = 0;
        acc22 = -1; acc_last = -1;
    endtask

    // Leaves the final pixel on the inputs; it is taken at the next rising edge.
    task automatic run_frame(input int pat, input bit gap, input int npix);
        int idx, tries;
        bit took;
        idx = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (idx < npix) begin
                    if (gap) begin
                        @(negedge Clock);
                        InValid = 1'b0;
                        #1;
                        if (BufWriteEnable !== 1'b0) we_err++;
                        if (BufAddr !== AW'(last_col_tb)) addr_err++;
                    end
                    took = 1'b0;
                    tries = 0;
                    while (!took && tries < 20) begin
                        @(negedge Clock);
                        InValid = 1'b1;
                        InData  = pix(pat, r, c);
                        #1;
                        if (BufWriteEnable !== InReady) we_err++;
                        if (InReady === 1'b1) begin
                            took = 1'b1;
                            if (BufAddr !== AW'(c)) addr_err++;
                            if (BufData !== InData) we_err++;
                            last_col_tb = c;
                            if (r == 2 && c == 2) acc22 = cyc + 1;
                            acc_last = cyc + 1;
                        end
                        tries++;
                    end
                    if (!took) tmo_err++;
                    idx++;
                end
            end
        end
    endtask

    task automatic go_idle();
        @(negedge Clock);
        InValid = 1'b0;
        InData  = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (fd_cnt < target && n < 60) begin
            @(negedge Clock);
            n++;
        end
        #2;
        n_cmp++;
        if (fd_cnt < target) begin
            n_bad++;
            $display("FAIL frame_done_timeout: got %0d pulses, required %0d", fd_cnt, target);
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0; InValid = 1'b0; InData = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        n_cmp += 9;
        if (InReady !== 1'b1)        begin n_bad++; $display("FAIL rst_inready: got %b, required 1", InReady); end
        if (BufWriteEnable !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b, required 0", BufWriteEnable); end
        if (BufAddr !== '0)          begin n_bad++; $display("FAIL rst_addr: got %0d, required 0", BufAddr); end
        if (BufData !== 1'b0)        begin n_bad++; $display("FAIL rst_bufdata: got %b, required 0", BufData); end
        if (WindowValid !== 1'b0)    begin n_bad++; $display("FAIL rst_wvalid: got %b, required 0", WindowValid); end
        if (Window !== '0)           begin n_bad++; $display("FAIL rst_window: got %h, required 0", Window); end
        if (WindowRow !== '0)        begin n_bad++; $display("FAIL rst_row: got %0d, required 0", WindowRow); end
        if (WindowCol !== '0)        begin n_bad++; $display("FAIL rst_col: got %0d, required 0", WindowCol); end
        if (FrameDone !== 1'b0)      begin n_bad++; $display("FAIL rst_framedone: got %b, required 0", FrameDone); end
        nReset = 1'b1;
        last_col_tb = 0;
    endtask

    task automatic test_ones();
        logic [AW:0] er;
        logic [AW-1:0] ec;
        clear_rec();
        run_frame(0, 1'b0, W*H);
        go_idle();
        wait_frames(1);
        n_cmp += 6;
        if (win_q.size() != 25) begin n_bad++; $display("FAIL ones_count: got %0d, required 25", win_q.size()); end
        if (first_win_cyc != acc22 + 1) begin n_bad++; $display("FAIL ones_latency: got cycle %0d, required %0d", first_win_cyc, acc22 + 1); end
        if (fd_cnt != 1) begin n_bad++; $display("FAIL ones_fd_count: got %0d, required 1", fd_cnt); end
        if (fd_cyc != acc_last + 2) begin n_bad++; $display("FAIL ones_fd_time: got cycle %0d, required %0d", fd_cyc, acc_last + 2); end
        if (we_err != 0 || tmo_err != 0) begin n_bad++; $display("FAIL ones_we: got %0d/%0d errors, required 0", we_err, tmo_err); end
        if (addr_err != 0) begin n_bad++; $display("FAIL ones_addr: got %0d errors, required 0", addr_err); end
        for (int i = 0; i < win_q.size() && i < 25; i++) begin
            er = (AW+1)'(2 + i / 5);
            ec = AW'(2 + i % 5);
            n_cmp++;
            if (win_q[i] !== 9'h1FF || row_q[i] !== er || col_q[i] !== ec) begin
                n_bad++;
                $display("FAIL ones_win[%0d]: got %h @(%0d,%0d), required 1ff @(%0d,%0d)",
                         i, win_q[i], row_q[i], col_q[i], er, ec);
            end
        end
    endtask

    task automatic test_checker();
        clear_rec();
        run_frame(1, 1'b0, W*H);
        go_idle();
        wait_frames(1);
        n_cmp++;
        if (win_q.size() != 25) begin n_bad++; $display("FAIL chk_count: got %0d, required 25", win_q.size()); end
        if (win_q.size() >= 2) begin
            // pixel (0,0) is 0, so the (2,2) window has zeros in its corners
            n_cmp += 2;
            if (win_q[0] !== 9'b010_101_010) begin n_bad++; $display("FAIL chk_win22: got %b, required 010101010", win_q[0]); end
            if (win_q[1] !== 9'b101_010_101) begin n_bad++; $display("FAIL chk_win23: got %b, required 101010101", win_q[1]); end
        end
        for (int i = 0; i < win_q.size() && i < 25; i++) begin
            n_cmp++;
            if (win_q[i] !== exp_win(1, 2 + i / 5, 2 + i % 5)) begin
                n_bad++;
                $display("FAIL chk_win[%0d]: got %b, required %b", i, win_q[i], exp_win(1, 2 + i / 5, 2 + i % 5));
            end
        end
    endtask

    task automatic test_gaps();
        clear_rec();
        run_frame(2, 1'b1, W*H);
        go_idle();
        wait_frames(1);
        n_cmp += 3;
        if (win_q.size() != 25) begin n_bad++; $display("FAIL gap_count: got %0d, required 25", win_q.size()); end
        if (we_err != 0 || tmo_err != 0) begin n_bad++; $display("FAIL gap_we: got %0d/%0d errors, required 0", we_err, tmo_err); end
        if (addr_err != 0) begin n_bad++; $display("FAIL gap_addr_hold: got %0d errors, required 0", addr_err); end
        for (int i = 0; i < win_q.size() && i < 25; i++) begin
            n_cmp++;
            if (win_q[i] !== exp_win(2, 2 + i / 5, 2 + i % 5) || col_q[i] !== AW'(2 + i % 5)) begin
                n_bad++;
                $display("FAIL gap_win[%0d]: got %b @col %0d, required %b @col %0d",
                         i, win_q[i], col_q[i], exp_win(2, 2 + i / 5, 2 + i % 5), 2 + i % 5);
            end
        end
    endtask

    task automatic test_midreset();
        clear_rec();
        run_frame(1, 1'b0, 3*W + 5);
        @(negedge Clock);
        InValid = 1'b0;
        nReset  = 1'b0;
        @(negedge Clock);
        nReset = 1'b1;
        last_col_tb = 0;
        #1;
        n_cmp++;
        if (WindowValid !== 1'b0 || InReady !== 1'b1) begin
            n_bad++;
            $display("FAIL mrst_state: got valid=%b ready=%b, required 0/1", WindowValid, InReady);
        end
        clear_rec();
        run_frame(2, 1'b0, W*H);
        go_idle();
        wait_frames(1);
        n_cmp += 3;
        if (win_q.size() != 25) begin n_bad++; $display("FAIL mrst_count: got %0d, required 25", win_q.size()); end
        if (win_q.size() > 0 && (row_q[0] !== 4'd2 || col_q[0] !== 3'd2)) begin
            n_bad++; $display("FAIL mrst_first: got (%0d,%0d), required (2,2)", row_q[0], col_q[0]);
        end
        if (first_win_cyc != acc22 + 1) begin n_bad++; $display("FAIL mrst_latency: got %0d, required %0d", first_win_cyc, acc22 + 1); end
        for (int i = 0; i < win_q.size() && i < 25; i++) begin
            n_cmp++;
            if (win_q[i] !== exp_win(2, 2 + i / 5, 2 + i % 5)) begin
                n_bad++;
                $display("FAIL mrst_win[%0d]: got %b, required %b", i, win_q[i], exp_win(2, 2 + i / 5, 2 + i % 5));
            end
        end
    endtask

    task automatic test_done_stall();
        clear_rec();
        run_frame(0, 1'b0, W*H);
        @(negedge Clock);
        InValid = 1'b1;
        InData  = 1'b1;
        #1;
        n_cmp += 2;
        if (InReady !== 1'b0) begin n_bad++; $display("FAIL done_inready: got %b, required 0", InReady); end
        if (BufWriteEnable !== 1'b0) begin n_bad++; $display("FAIL done_we: got %b, required 0", BufWriteEnable); end
        run_frame(1, 1'b0, W*H);
        go_idle();
        wait_frames(2);
        n_cmp += 4;
        if (fd_cnt != 2) begin n_bad++; $display("FAIL done_fd: got %0d, required 2", fd_cnt); end
        if (win_q.size() != 50) begin n_bad++; $display("FAIL done_count: got %0d, required 50", win_q.size()); end
        if (addr_err != 0 || we_err != 0 || tmo_err != 0) begin
            n_bad++; $display("FAIL done_restart: got %0d/%0d/%0d errors, required 0", addr_err, we_err, tmo_err);
        end
        if (win_q.size() > 25 && (win_q[25] !== exp_win(1, 2, 2) || row_q[25] !== 4'd2 || col_q[25] !== 3'd2)) begin
            n_bad++; $display("FAIL done_next_first: got %b @(%0d,%0d), required %b @(2,2)",
                              win_q[25], row_q[25], col_q[25], exp_win(1, 2, 2));
        end
    endtask

    task automatic test_back_to_back();
        logic [AW:0] er;
        logic [AW-1:0] ec;
        int pat;
        clear_rec();
        run_frame(2, 1'b0, W*H);
        run_frame(0, 1'b0, W*H);
        go_idle();
        wait_frames(2);
        n_cmp += 2;
        if (fd_cnt != 2) begin n_bad++; $display("FAIL b2b_fd: got %0d, required 2", fd_cnt); end
        if (win_q.size() != 50) begin n_bad++; $display("FAIL b2b_count: got %0d, required 50", win_q.size()); end
        for (int i = 0; i < win_q.size() && i < 50; i++) begin
            er  = (AW+1)'(2 + (i % 25) / 5);
            ec  = AW'(2 + i % 5);
            pat = (i < 25) ? 2 : 0;
            n_cmp++;
            if (row_q[i] !== er || col_q[i] !== ec || win_q[i] !== exp_win(pat, er, ec)) begin
                n_bad++;
                $display("FAIL b2b_win[%0d]: got %b @(%0d,%0d), required %b @(%0d,%0d)",
                         i, win_q[i], row_q[i], col_q[i], exp_win(pat, er, ec), er, ec);
            end
        end
    endtask

    initial begin
        clear_rec();
        test_reset();
        test_ones();
        test_checker();
        test_gaps();
        test_midreset();
        test_done_stall();
        test_back_to_back();
        repeat (3) @(negedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1);
    end

endmodule
